cnn_frame_scheduler: RTL
========================

# cnn_frame_scheduler

Frame-level controller that sits in front of the CNN datapath top (conv/pool/FC pipeline). It buffers one 28x28 image arriving over a valid/ready stream, replays it into the pipeline as an unbroken 784-cycle `valid_in` burst, and waits for the FC layer's done pulse. It then presents the predicted digit over a valid/ready result port, and guarantees a drain gap between frames. The datapath has no backpressure, so this block enforces all frame-level sequencing.

## Interface
- `DATA_W`, 8, pixel width (signed)
- `IMG_W`, 28, image width
- `IMG_H`, 28, image height; `FRAME_PIX = IMG_W*IMG_H` (784)
- `GAP_CYC`, 64, idle cycles after each result before the next frame is accepted
- `TIMEOUT_CYC`, 4096, maximum WAIT cycles (used only with the timeout macro)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `s_valid`  in  1  host pixel valid
- `s_ready`  out  1  host pixel ready
- `s_data`  in  DATA_W  host pixel
- `s_last`  in  1  host end-of-frame marker
- `cnn_valid`  out  1  drives datapath `valid_in`
- `cnn_data`  out  DATA_W  drives datapath `data_in`
- `cnn_done`  in  1  datapath FC done pulse
- `cnn_digit`  in  4  datapath predicted class, valid with `cnn_done`
- `m_valid`  out  1  result valid
- `m_ready`  in  1  result ready
- `m_digit`  out  4  result class
- `m_timeout`  out  1  result is a timeout, qualified by `m_valid`
- `busy`  out  1  high in every state except LOAD
- `err_frame`  out  1  sticky: early `s_last` seen; cleared only by reset
- `frame_cnt`  out  16  count of completed results, wraps at 2^16

## Operation
States and transitions:
- LOAD:
  - `s_ready`=1.
  - Each beat with `s_valid&s_ready` writes `s_data` to `buf[wr_ptr]` and increments `wr_ptr`.
  - The beat at `wr_ptr==FRAME_PIX-1` completes the frame: go to STREAM with `wr_ptr`=0. `s_last` on this beat is optional.
  - `s_last` on any earlier beat aborts the frame: the pixel is discarded, `wr_ptr`=0, `err_frame`=1, stay in LOAD.
- STREAM:
  - `s_ready`=0.
  - `rd_ptr` runs 0..FRAME_PIX-1, one address per cycle, no gaps.
  - Buffer read is synchronous. `cnn_valid`/`cnn_data` are registered from the read port, aligned so `cnn_valid` is high for exactly FRAME_PIX consecutive cycles carrying `buf[0]`..`buf[783]` in order.
  - After the last pixel is issued, go to WAIT.
- WAIT:
  - Wait for `cnn_done`. On `cnn_done`=1: latch `cnn_digit` into `m_digit`, `m_timeout`=0, go to RESULT.
- RESULT:
  - `m_valid`=1, with `m_digit`/`m_timeout` stable.
  - On `m_valid&m_ready`: `m_valid`=0, `frame_cnt`+1, go to GAP.
- GAP:
  - Count GAP_CYC cycles, then go to LOAD.

Rules:
- `cnn_done` outside WAIT is ignored.
- `cnn_done` in the same cycle WAIT is entered is accepted.
- `cnn_valid`=0 and `cnn_data`=0 whenever not streaming.
- Counters are sized to `$clog2` of their bound and must not wrap inside a state.
- Reset mid-operation: all state is lost, the partial frame is discarded, the next frame starts at pixel 0.

## Timing
- Reset values: `s_ready`=0, `cnn_valid`=0, `cnn_data`=0, `m_valid`=0, `m_digit`=0, `m_timeout`=0, `busy`=0, `err_frame`=0, `frame_cnt`=0. The state resets to LOAD.
- `s_ready` is registered: it rises on the first clock edge after reset release.
- Last LOAD beat accepted at edge T: the first `cnn_valid` is high in cycle T+2 (address at T+1, read data registered at T+2). The last `cnn_valid` is in cycle T+785.
- `cnn_done` sampled at edge D: `m_valid`=1 from D+1.
- Handshake at edge H: `s_ready` rises at H+GAP_CYC+1.
- `m_valid` never drops without `m_ready`. `m_digit` is stable while `m_valid`=1.

## Configuration
- `CNN_SCHED_TIMEOUT_EN` defined:
  - WAIT counts cycles. After TIMEOUT_CYC cycles without `cnn_done`, go to RESULT with `m_digit`=4'hF and `m_timeout`=1.
  - A `cnn_done` arriving on the expiry cycle wins.
- Not defined:
  - WAIT waits indefinitely. `m_timeout` is tied 0 and the counter is not synthesized.

## Structure
- Package `cnn_sched_pkg`: state enum (LOAD, STREAM, WAIT, RESULT, GAP), `FRAME_PIX` default, and timeout digit constant `DIGIT_TIMEOUT`=4'hF.
- One sub-module, `frame_buffer`: simple dual-port RAM, FRAME_PIX x DATA_W, one write port, one synchronous read port with 1-cycle latency, no reset on the array.
- The FSM, pointers, and output registers live in `cnn_frame_scheduler`.

## Test plan
- **Ramp frame, continuous `s_valid`:** pixels 0..783 = k mod 128 → `cnn_valid` high exactly 784 consecutive cycles, data matches, first valid at T+2.
- **Throttled input:** `s_valid` random 50% → identical `cnn_data` sequence, no gaps in `cnn_valid`.
- **Done and result backpressure:** `cnn_done` with digit 7 pulsed 300 cycles after STREAM ends; `m_ready` held low 20 cycles → `m_valid` held with `m_digit`=7, `frame_cnt`=1 after the handshake, `s_ready` returns exactly GAP_CYC+1 cycles later.
- **Early `s_last`:** `s_last` on pixel 100 → `err_frame`=1, no `cnn_valid`; the next full 784-pixel frame streams correctly starting from its own pixel 0.
- **Timeout (with macro, TIMEOUT_CYC=4096), no `cnn_done`:** → `m_valid` with `m_digit`=4'hF, `m_timeout`=1. Without the macro: still waiting after 10000 cycles.
- **Reset mid-STREAM:** `rst_n` low at pixel 400 → all outputs at reset values immediately; a subsequent frame yields a correct 784-cycle burst.

Source files
------------

// File: rtl/cnn_sched_pkg.sv
// Shared types and constants for the CNN frame scheduler.
package cnn_sched_pkg;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_STREAM = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESULT = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  localparam int         FRAME_PIX     = 784;
  localparam logic [3:0] DIGIT_TIMEOUT = 4'hF;

endpackage

// File: rtl/frame_buffer.sv
// One-frame pixel store: single write port, synchronous read port with one
// cycle of latency. The array itself carries no reset.
module frame_buffer
  import cnn_sched_pkg::*;
#(
  parameter int DEPTH  = FRAME_PIX,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cnn_frame_scheduler.sv
// Frame-level sequencer in front of the CNN datapath: load, replay, wait, result, gap.
// Optional WAIT timeout enabled by defining CNN_SCHED_TIMEOUT_EN.
module cnn_frame_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int GAP_CYC     = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     cnn_valid,
  output logic signed [DATA_W-1:0] cnn_data,
  input  logic                     cnn_done,
  input  logic [3:0]               cnn_digit,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [3:0]               m_digit,
  output logic                     m_timeout,
  output logic                     busy,
  output logic                     err_frame,
  output logic [15:0]              frame_cnt
);

  localparam int              NPIX     = IMG_W * IMG_H;
  localparam int              PW       = $clog2(NPIX);
  localparam int              GW       = $clog2(GAP_CYC + 1);
  localparam logic [PW-1:0]   LAST_PIX = PW'(NPIX - 1);
  localparam logic [GW-1:0]   GAP_END  = GW'(GAP_CYC);

  state_e                   state_q, state_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [GW-1:0]            gap_cnt_q, gap_cnt_d;
  logic                     issue_q, issue_d;
  logic                     s_ready_q, s_ready_d;
  logic                     cnn_valid_q, cnn_valid_d;
  logic [DATA_W-1:0]        cnn_data_q, cnn_data_d;
  logic                     m_valid_q, m_valid_d;
  logic [3:0]               m_digit_q, m_digit_d;
  logic                     m_timeout_q, m_timeout_d;
  logic                     busy_q, busy_d;
  logic                     err_frame_q, err_frame_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic                     beat, wr_en, timeout_hit;
  logic [DATA_W-1:0]        rd_data;

  // s_ready_q is only high in LOAD, so it doubles as the accept qualifier
  assign beat  = s_valid & s_ready_q;
  assign wr_en = beat & ~(s_last & (wr_ptr_q != LAST_PIX));

  frame_buffer #(.DEPTH(NPIX), .DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (s_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

`ifdef CNN_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;

  // WAIT dwell counter, cleared outside WAIT
  always_comb begin
    if (state_q == ST_WAIT) begin
      wait_cnt_d = wait_cnt_q + TW'(1);
    end else begin
      wait_cnt_d = '0;
    end
  end

  // WAIT dwell counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and output-register computation
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    gap_cnt_d   = gap_cnt_q;
    issue_d     = 1'b0;
    m_digit_d   = m_digit_q;
    m_timeout_d = m_timeout_q;
    err_frame_d = err_frame_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (beat && (wr_ptr_q == LAST_PIX)) begin
          state_d  = ST_STREAM;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else if (beat && s_last) begin
          wr_ptr_d    = '0;
          err_frame_d = 1'b1;
        end else if (beat) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      ST_STREAM: begin
        issue_d = 1'b1;
        if (rd_ptr_q == LAST_PIX) begin
          state_d  = ST_WAIT;
          rd_ptr_d = '0;
        end else begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
      end
      ST_WAIT: begin
        // A done pulse on the expiry cycle takes priority over the timeout
        if (cnn_done) begin
          m_digit_d   = cnn_digit;
          m_timeout_d = 1'b0;
          state_d     = ST_RESULT;
        end else if (timeout_hit) begin
          m_digit_d   = DIGIT_TIMEOUT;
          m_timeout_d = 1'b1;
          state_d     = ST_RESULT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESULT: begin
        if (m_valid_q && m_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          gap_cnt_d   = '0;
          state_d     = ST_GAP;
        end else begin
          state_d = ST_RESULT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_END) begin
          gap_cnt_d = '0;
          state_d   = ST_LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
    s_ready_d   = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_LOAD);
    m_valid_d   = (state_q == ST_RESULT) && !(m_valid_q && m_ready);
    cnn_valid_d = issue_q;
    cnn_data_d  = issue_q ? rd_data : '0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      issue_q     <= 1'b0;
      s_ready_q   <= 1'b0;
      cnn_valid_q <= 1'b0;
      cnn_data_q  <= '0;
      m_valid_q   <= 1'b0;
      m_digit_q   <= 4'd0;
      m_timeout_q <= 1'b0;
      busy_q      <= 1'b0;
      err_frame_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      issue_q     <= issue_d;
      s_ready_q   <= s_ready_d;
      cnn_valid_q <= cnn_valid_d;
      cnn_data_q  <= cnn_data_d;
      m_valid_q   <= m_valid_d;
      m_digit_q   <= m_digit_d;
      m_timeout_q <= m_timeout_d;
      busy_q      <= busy_d;
      err_frame_q <= err_frame_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign cnn_valid = cnn_valid_q;
  assign cnn_data  = cnn_data_q;
  assign m_valid   = m_valid_q;
  assign m_digit   = m_digit_q;
  assign m_timeout = m_timeout_q;
  assign busy      = busy_q;
  assign err_frame = err_frame_q;
  assign frame_cnt = frame_cnt_q;

endmodule
